// File: rtl/ecp_ddr_bank.sv
// rtl/ecp_ddr_bank.sv - DDR pin bank with direction turnaround FSM and aligned receive pipeline
// Includes single-clock behavioural models of the ODDRX1F/IDDRX1F pad primitives.
module ecp_ddr_bank #(
  parameter int NW         = 8,
  parameter int IDELAY     = 2,
  parameter int TURNAROUND = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_dir,
  input  logic            i_stb,
  input  logic [2*NW-1:0] i_data,
  output logic            o_ready,
  output logic            o_drive,
  output logic            o_valid,
  output logic [2*NW-1:0] o_data,
  inout  wire  [NW-1:0]   io_pin
);
  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [2*NW-1:0] tx_word;
  logic            pad_en;
  logic            rx_samp;
  logic [IDELAY:0] qual;
  logic [2*NW-1:0] pipe [IDELAY+1];
  logic [NW-1:0]   oddr_q;
  logic [NW-1:0]   iddr_q0;
  logic [NW-1:0]   iddr_q1;

  // Ready drops combinationally in the cycle the receive request is seen.
  assign o_ready = (state == TX) && i_dir;
  assign o_drive = pad_en;
  assign o_valid = qual[IDELAY];
  assign o_data  = pipe[IDELAY];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RX;
      cnt   <= '0;
    end else begin
      case (state)
        RX: if (i_dir) begin
          state <= TURN_TX;
          cnt   <= TURN_LOAD;
        end
        TURN_TX: if (cnt == '0) state <= TX; else cnt <= cnt - 4'd1;
        TX: if (!i_dir) begin
          state <= TURN_RX;
          cnt   <= TURN_LOAD;
        end
        TURN_RX: if (cnt == '0) state <= RX; else cnt <= cnt - 4'd1;
        default: state <= RX;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_word <= '0;
      pad_en  <= 1'b0;
    end else begin
      if (o_ready && i_stb) tx_word <= i_data;
      pad_en <= (state == TX);
    end
  end

  // rx_samp tags the word the IDDR presents this cycle, matching its one-cycle latency.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_samp <= 1'b0;
      qual    <= '0;
      for (int i = 0; i <= IDELAY; i++) pipe[i] <= '0;
    end else begin
      rx_samp <= (state == RX) && !pad_en;
      qual[0] <= rx_samp;
      if (rx_samp) pipe[0] <= {iddr_q0, iddr_q1};
      for (int i = 1; i <= IDELAY; i++) begin
        qual[i] <= qual[i-1];
        if (qual[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_pin
    ODDRX1F u_oddr (.D0(tx_word[NW+g]), .D1(tx_word[g]), .SCLK(i_clk), .RST(1'b0), .Q(oddr_q[g]));
    IDDRX1F u_iddr (.D(io_pin[g]), .SCLK(i_clk), .RST(1'b0), .Q0(iddr_q0[g]), .Q1(iddr_q1[g]));
    assign io_pin[g] = pad_en ? oddr_q[g] : 1'bz;
  end
endmodule

module ODDRX1F (
  input  logic D0,
  input  logic D1,
  input  logic SCLK,
  input  logic RST,
  output logic Q
);
  logic r0, r1;

  always_ff @(posedge SCLK) begin
    if (RST) begin
      r0 <= 1'b0;
      r1 <= 1'b0;
    end else begin
      r0 <= D0;
      r1 <= D1;
    end
  end

  // D0 is presented while the clock is high, D1 while it is low.
  assign Q = SCLK ? r0 : r1;
endmodule

module IDDRX1F (
  input  logic D,
  input  logic SCLK,
  input  logic RST,
  output logic Q0,
  output logic Q1
);
  logic rise, fall;

  always_ff @(posedge SCLK) begin
    if (RST) begin
      rise <= 1'b0;
      Q0   <= 1'b0;
      Q1   <= 1'b0;
    end else begin
      rise <= D;
      Q0   <= rise;
      Q1   <= fall;
    end
  end

  always_ff @(negedge SCLK) begin
    if (RST) fall <= 1'b0;
    else     fall <= D;
  end
endmodule

// File: tb/tb_ecp_ddr_bank.sv
// tb/tb_ecp_ddr_bank.sv - randomized bench against a turnaround/latency reference model
module tb_ecp_ddr_bank;
  localparam int NW         = 8;
  localparam int IDELAY     = 2;
  localparam int TURNAROUND = 2;
  localparam int LAT        = IDELAY + 2;
  localparam int HMAX       = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dir;
  logic            stb;
  logic [2*NW-1:0] data;
  logic            ready;
  logic            drive;
  logic            valid;
  logic [2*NW-1:0] odata;
  logic [NW-1:0]   far_val;
  wire  [NW-1:0]   pins;

  always #10 clk = ~clk;

  // Far end drives whenever the bank is not driving.
  assign pins = drive ? {NW{1'bz}} : far_val;

  ecp_ddr_bank #(.NW(NW), .IDELAY(IDELAY), .TURNAROUND(TURNAROUND)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_dir(dir), .i_stb(stb), .i_data(data),
    .o_ready(ready), .o_drive(drive), .o_valid(valid), .o_data(odata), .io_pin(pins)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a stable direction plus the cycle at which the current turn ends.
  int              cyc;
  logic            stable_dir;
  int              turn_end;
  logic            prev_istx;
  logic [15:0]     last_acc;
  logic            exp_valid;
  logic [15:0]     exp_data;
  logic [7:0]      fa_cur;
  bit              const_far;
  bit              rxok_h [HMAX];
  logic [15:0]     word_h [HMAX];
  logic [15:0]     acc_h  [HMAX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick_a();
    return const_far ? 8'hA5 : 8'($urandom);
  endfunction

  function automatic logic [7:0] pick_b();
    return const_far ? 8'h3C : 8'($urandom);
  endfunction

  // Entered half a cycle before a rising edge; the release cycle becomes model cycle 0.
  task automatic pulse_reset();
    logic [7:0] fb;
    rst_n = 1'b0;
    dir = 1'b0;
    stb = 1'b0;
    #1;
    check("rst_drive", drive, 0);
    check("rst_ready", ready, 0);
    check("rst_valid", valid, 0);
    check("rst_data", odata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #5;
    fa_cur = pick_a();
    far_val = fa_cur;
    @(posedge clk); #5;
    fb = pick_b();
    far_val = fb;
    @(negedge clk); #2;
    rst_n = 1'b1;
    #3;
    check("rel_drive", drive, 0);
    check("rel_valid", valid, 0);
    check("rel_data", odata, 0);
    stable_dir = 1'b0;
    turn_end   = -1;
    prev_istx  = 1'b0;
    last_acc   = '0;
    exp_valid  = 1'b0;
    exp_data   = '0;
    rxok_h[0]  = 1'b1;
    word_h[0]  = {fa_cur, fb};
    acc_h[0]   = '0;
    fa_cur  = pick_a();
    far_val = fa_cur;
    cyc = 1;
  endtask

  task automatic step(input logic d, input logic s, input logic [15:0] w);
    int         k;
    logic       turning, istx, exp_drive, exp_ready, rxok;
    logic [15:0] txw;
    logic [7:0] fb;
    @(posedge clk); #1;
    dir = d;
    stb = s;
    data = w;
    #1;
    k = cyc;
    turning   = (k <= turn_end);
    istx      = !turning && stable_dir;
    exp_drive = prev_istx;
    exp_ready = istx && d;
    rxok      = !turning && !stable_dir && !exp_drive;
    exp_valid = (k >= LAT) && rxok_h[k-LAT];
    if (exp_valid) exp_data = word_h[k-LAT];
    txw = (k >= 2) ? acc_h[k-2] : 16'h0;
    check("ready", ready, exp_ready);
    check("drive", drive, exp_drive);
    check("valid", valid, exp_valid);
    check("rdata", odata, exp_data);
    #3;
    if (exp_drive) check("pad_hi", pins, txw[15:8]);
    fb = pick_b();
    far_val = fb;
    @(negedge clk); #5;
    if (exp_drive) check("pad_lo", pins, txw[7:0]);
    rxok_h[k] = rxok;
    word_h[k] = {fa_cur, fb};
    if (exp_ready && s) last_acc = w;
    acc_h[k] = last_acc;
    if (!turning && d != stable_dir) begin
      stable_dir = d;
      turn_end   = k + TURNAROUND;
    end
    prev_istx = istx;
    fa_cur  = pick_a();
    far_val = fa_cur;
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL history_overflow got=%0d exp<%0d", cyc, HMAX);
      $fatal(1, "history overflow");
    end
  endtask

  initial begin
    logic rdir;
    rst_n = 1'b0;
    dir = 1'b0;
    stb = 1'b0;
    data = '0;
    far_val = '0;
    const_far = 1'b1;
    pulse_reset();
    repeat (9) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    repeat (2) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h1234);
    repeat (5) step(1'b1, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'hBEEF);
    repeat (4) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h5A5A);
    step(1'b0, 1'b1, 16'h6B6B);
    repeat (8) step(1'b0, 1'b1, 16'h7C7C);
    const_far = 1'b0;
    rdir = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) rdir = ~rdir;
      step(rdir, 1'($urandom_range(1)), 16'($urandom));
    end
    repeat (10) step(1'b1, 1'b1, 16'($urandom));
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(5) == 0) rdir = ~rdir;
      step(rdir, 1'($urandom_range(1)), 16'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
